// File: rtl/u_rf_if.sv
// u_rf_if: bundle of the register-file access signals.
//   master : drives read addresses, the write-back stream and debug requests
//   slave  : the register file; returns read data, debug data/ack and init_busy
// Signals:
//   rs1_a / rs2_a        read port addresses
//   rf_rs1_o / rf_rs2_o  read port data (combinational)
//   rf_rd_e/_a/_i        write enable / address / data
//   dbg_req / dbg_a      debug read request (level) and address
//   dbg_ack / dbg_d      debug read done pulse and data (held)
//   init_busy            clear sweep in progress
interface u_rf_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rs1_a;
  logic [4:0]      rs2_a;
  logic [XLEN-1:0] rf_rs1_o;
  logic [XLEN-1:0] rf_rs2_o;
  logic            rf_rd_e;
  logic [4:0]      rf_rd_a;
  logic [XLEN-1:0] rf_rd_i;
  logic            dbg_req;
  logic [4:0]      dbg_a;
  logic            dbg_ack;
  logic [XLEN-1:0] dbg_d;
  logic            init_busy;

  modport master (
    output rs1_a, rs2_a, rf_rd_e, rf_rd_a, rf_rd_i, dbg_req, dbg_a,
    input  rf_rs1_o, rf_rs2_o, dbg_ack, dbg_d, init_busy
  );

  modport slave (
    input  rs1_a, rs2_a, rf_rd_e, rf_rd_a, rf_rd_i, dbg_req, dbg_a,
    output rf_rs1_o, rf_rs2_o, dbg_ack, dbg_d, init_busy
  );
endinterface

// File: rtl/u_rf.sv
// u_rf: RV32 integer register file with two combinational read ports, one
// write-back port, a req/ack debug read port and a post-reset clear sweep.
// Ports:
//   clk  clock (rising edge)
//   rst  synchronous active-high reset
//   rf   u_rf_if.slave bundle (read ports, write port, debug port, init_busy)
// Storage has no reset term; after rst falls, an INIT sweep clears entries
// 1..NREG-1, one per cycle. Reads return 0 until the sweep has completed.
module u_rf #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input logic   clk,
  input logic   rst,
  u_rf_if.slave rf
);

  localparam int         AW   = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [4:0] LAST = 5'(NREG - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [4:0]      cnt_reg, cnt_next;
  logic [XLEN-1:0] regs [NREG];
  logic            dbg_ack_reg;
  logic [XLEN-1:0] dbg_d_reg;

  // Addresses beyond the implemented registers read as 0 and never write.
  function automatic logic in_range(input logic [4:0] a);
    return {1'b0, a} < 6'(NREG);
  endfunction

  // ---------------- state register and sweep counter ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_INIT;
      cnt_reg   <= 5'd1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == S_INIT) begin
      cnt_next = cnt_reg + 5'd1;
      // The last entry is cleared on this same edge, so RUN starts clean.
      if (cnt_reg == LAST) begin
        state_next = S_RUN;
      end
    end
  end

  // ---------------- storage: sweep clear or write-back ----------------
  // Entry 0 is never written: the sweep starts at 1 and writes to x0 drop.
  // Write-back during INIT is discarded rather than queued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == S_INIT) begin
        regs[cnt_reg[AW-1:0]] <= '0;
      end else if (rf.rf_rd_e && (rf.rf_rd_a != 5'd0) && in_range(rf.rf_rd_a)) begin
        regs[rf.rf_rd_a[AW-1:0]] <= rf.rf_rd_i;
      end
    end
  end

  // ---------------- read ports: rs1, rs2, debug ----------------
  // All three share one lookup rule, including the same-cycle bypass.
  logic [2:0][4:0] port_a;
  assign port_a = {rf.dbg_a, rf.rs2_a, rf.rs1_a};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rd
      logic [XLEN-1:0] rd_d;
      always_comb begin
        rd_d = '0;
        if ((state_reg == S_RUN) && (port_a[gi] != 5'd0) && in_range(port_a[gi])) begin
          if ((BYPASS != 0) && rf.rf_rd_e && (rf.rf_rd_a == port_a[gi])) begin
            rd_d = rf.rf_rd_i;
          end else begin
            rd_d = regs[port_a[gi][AW-1:0]];
          end
        end
      end
    end
  endgenerate

  // ---------------- debug responder ----------------
  // A request is taken whenever ack is low, so a request still held while
  // ack is high is served again one cycle later (one read per 2 cycles).
  // Requests stall through INIT and are taken on the first RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_ack_reg <= 1'b0;
      dbg_d_reg   <= '0;
    end else if ((state_reg == S_RUN) && rf.dbg_req && !dbg_ack_reg) begin
      dbg_ack_reg <= 1'b1;
      dbg_d_reg   <= g_rd[2].rd_d;
    end else begin
      dbg_ack_reg <= 1'b0;
    end
  end

  assign rf.rf_rs1_o  = g_rd[0].rd_d;
  assign rf.rf_rs2_o  = g_rd[1].rd_d;
  assign rf.dbg_ack   = dbg_ack_reg;
  assign rf.dbg_d     = dbg_d_reg;
  assign rf.init_busy = (state_reg == S_INIT);

endmodule

// File: tb/tb_u_rf.sv
// Scoreboard bench for u_rf: stimulus pushes expected values into queues,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_u_rf;

  localparam int ID_RS1  = 0;
  localparam int ID_RS2  = 1;
  localparam int ID_BUSY = 2;
  localparam int ID_ACK  = 3;
  localparam int ID_DBGD = 4;

  typedef struct {
    int          id;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  chk_t        rd_q[$];
  logic [31:0] dbg_q[$];

  u_rf_if #(.XLEN(32)) ifc ();

  u_rf #(
    .XLEN  (32),
    .NREG  (32),
    .BYPASS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rf (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int id, input logic [31:0] v, input string n);
    chk_t it;
    it.id   = id;
    it.exp  = v;
    it.name = n;
    rd_q.push_back(it);
  endtask

  task automatic drive_wr(input logic e, input logic [4:0] a, input logic [31:0] d);
    ifc.rf_rd_e = e;
    ifc.rf_rd_a = a;
    ifc.rf_rd_i = d;
  endtask

  // Monitor: compares everything queued for this cycle, and consumes one
  // debug expectation each time the DUT presents dbg_ack.
  always @(negedge clk) begin : monitor
    chk_t        it;
    logic [31:0] act;
    logic [31:0] e;
    while (rd_q.size() > 0) begin
      it = rd_q.pop_front();
      case (it.id)
        ID_RS1:  act = ifc.rf_rs1_o;
        ID_RS2:  act = ifc.rf_rs2_o;
        ID_BUSY: act = {31'd0, ifc.init_busy};
        ID_ACK:  act = {31'd0, ifc.dbg_ack};
        default: act = ifc.dbg_d;
      endcase
      n_total++;
      if (act === it.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
    end
    if (ifc.dbg_ack === 1'b1) begin
      n_total++;
      if (dbg_q.size() == 0) begin
        $display("FAIL dbg_unexpected_ack: got ack with dbg_d %h expected no ack", ifc.dbg_d);
      end else begin
        e = dbg_q.pop_front();
        if (ifc.dbg_d === e) n_pass++;
        else $display("FAIL dbg_d_on_ack: got %h expected %h", ifc.dbg_d, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    ifc.rs1_a = 5'd0;
    ifc.rs2_a = 5'd0;
    drive_wr(1'b0, 5'd0, 32'h0);
    ifc.dbg_req = 1'b0;
    ifc.dbg_a   = 5'd0;

    // Reset held for two edges.
    step();
    expect_val(ID_BUSY, 32'd1, "busy_in_reset");
    expect_val(ID_ACK,  32'd0, "ack_in_reset");
    expect_val(ID_DBGD, 32'd0, "dbgd_in_reset");
    step();
    rst = 1'b0;

    // Sweep: busy for 31 cycles; a write to x3 in sweep cycle 10 is dropped.
    for (int c = 0; c < 31; c++) begin
      ifc.rs1_a = (c == 10) ? 5'd3 : 5'(c);
      ifc.rs2_a = 5'(31 - c);
      drive_wr(c == 10, 5'd3, 32'h0000_00AA);
      expect_val(ID_BUSY, 32'd1, $sformatf("busy_c%0d", c));
      expect_val(ID_RS1, 32'd0, $sformatf("init_rs1_c%0d", c));
      expect_val(ID_RS2, 32'd0, $sformatf("init_rs2_c%0d", c));
      step();
    end
    drive_wr(1'b0, 5'd0, 32'h0);
    expect_val(ID_BUSY, 32'd0, "busy_done");

    // Every register reads zero after the sweep (x3 included).
    for (int a = 0; a < 32; a++) begin
      ifc.rs1_a = 5'(a);
      ifc.rs2_a = 5'(31 - a);
      expect_val(ID_RS1, 32'd0, $sformatf("clear_rs1_x%0d", a));
      expect_val(ID_RS2, 32'd0, $sformatf("clear_rs2_x%0d", 31 - a));
      step();
    end

    // Write x5, bypassed in the write cycle, stored afterwards; x6 untouched.
    drive_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
    ifc.rs1_a = 5'd5; ifc.rs2_a = 5'd6;
    expect_val(ID_RS1, 32'hDEAD_BEEF, "x5_bypass");
    expect_val(ID_RS2, 32'd0, "x6_zero_a");
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    expect_val(ID_RS1, 32'hDEAD_BEEF, "x5_stored");
    expect_val(ID_RS2, 32'd0, "x6_zero_b");
    step();

    // Both ports hit the bypass on x9 simultaneously.
    drive_wr(1'b1, 5'd9, 32'h1234_5678);
    ifc.rs1_a = 5'd9; ifc.rs2_a = 5'd9;
    expect_val(ID_RS1, 32'h1234_5678, "x9_bypass_rs1");
    expect_val(ID_RS2, 32'h1234_5678, "x9_bypass_rs2");
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    expect_val(ID_RS1, 32'h1234_5678, "x9_stored_rs1");
    expect_val(ID_RS2, 32'h1234_5678, "x9_stored_rs2");
    step();

    // x0 write is dropped and never bypassed.
    drive_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    ifc.rs1_a = 5'd0; ifc.rs2_a = 5'd0;
    expect_val(ID_RS1, 32'd0, "x0_nobypass_rs1");
    expect_val(ID_RS2, 32'd0, "x0_nobypass_rs2");
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    expect_val(ID_RS1, 32'd0, "x0_after");
    step();

    // Matching address with enable low neither bypasses nor writes.
    drive_wr(1'b0, 5'd5, 32'h0000_0111);
    ifc.rs1_a = 5'd5; ifc.rs2_a = 5'd9;
    expect_val(ID_RS1, 32'hDEAD_BEEF, "x5_no_enable");
    expect_val(ID_RS2, 32'h1234_5678, "x9_no_enable");
    step();
    expect_val(ID_RS1, 32'hDEAD_BEEF, "x5_no_enable_after");
    step();

    // Overwrite x5.
    drive_wr(1'b1, 5'd5, 32'h0BAD_F00D);
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    expect_val(ID_RS1, 32'h0BAD_F00D, "x5_overwrite");
    step();

    // Debug read of x12: ack one cycle after request, data held afterwards.
    drive_wr(1'b1, 5'd12, 32'hCAFE_F00D);
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    ifc.dbg_req = 1'b1; ifc.dbg_a = 5'd12;
    dbg_q.push_back(32'hCAFE_F00D);
    expect_val(ID_ACK, 32'd0, "dbg12_ack_low_at_req");
    step();
    expect_val(ID_ACK, 32'd1, "dbg12_ack");
    ifc.dbg_req = 1'b0;
    step();
    expect_val(ID_ACK, 32'd0, "dbg12_ack_drop");
    expect_val(ID_DBGD, 32'hCAFE_F00D, "dbg12_hold");
    step();

    // Debug read sees the same-cycle bypass.
    drive_wr(1'b1, 5'd13, 32'h1313_1313);
    ifc.dbg_req = 1'b1; ifc.dbg_a = 5'd13;
    dbg_q.push_back(32'h1313_1313);
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    ifc.dbg_req = 1'b0;
    expect_val(ID_ACK, 32'd1, "dbg13_ack");
    step();
    expect_val(ID_ACK, 32'd0, "dbg13_ack_drop");
    step();

    // Held request is re-served every other cycle.
    ifc.dbg_req = 1'b1; ifc.dbg_a = 5'd5;
    dbg_q.push_back(32'h0BAD_F00D);
    dbg_q.push_back(32'h0BAD_F00D);
    expect_val(ID_ACK, 32'd0, "held_w0");
    step();
    expect_val(ID_ACK, 32'd1, "held_w1");
    step();
    expect_val(ID_ACK, 32'd0, "held_w2");
    step();
    expect_val(ID_ACK, 32'd1, "held_w3");
    ifc.dbg_req = 1'b0;
    step();
    expect_val(ID_ACK, 32'd0, "held_w4");
    step();

    // Reset mid-run with a pending debug request on x7.
    drive_wr(1'b1, 5'd7, 32'h0000_0055);
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    ifc.rs1_a = 5'd7;
    expect_val(ID_RS1, 32'h0000_0055, "x7_before_reset");
    rst = 1'b1;
    ifc.dbg_req = 1'b1; ifc.dbg_a = 5'd7;
    dbg_q.push_back(32'd0);
    step();
    rst = 1'b0;
    expect_val(ID_ACK, 32'd0, "rst_ack_low");
    expect_val(ID_BUSY, 32'd1, "rst_busy");
    expect_val(ID_DBGD, 32'd0, "rst_dbgd_clear");
    expect_val(ID_RS1, 32'd0, "rst_x7_zero");
    step();
    for (int c = 1; c < 31; c++) begin
      expect_val(ID_BUSY, 32'd1, $sformatf("rbusy_c%0d", c));
      expect_val(ID_ACK, 32'd0, $sformatf("rstall_c%0d", c));
      step();
    end
    expect_val(ID_BUSY, 32'd0, "rbusy_done");
    expect_val(ID_ACK, 32'd0, "rstall_first_run");
    step();
    expect_val(ID_ACK, 32'd1, "rst_dbg_ack");
    ifc.dbg_req = 1'b0;
    step();
    expect_val(ID_ACK, 32'd0, "rst_dbg_ack_drop");
    expect_val(ID_RS1, 32'd0, "x7_lost");
    expect_val(ID_DBGD, 32'd0, "rst_dbgd_hold");
    step();
    drive_wr(1'b1, 5'd7, 32'h0000_0077);
    expect_val(ID_RS1, 32'h0000_0077, "x7_rewrite_bypass");
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    expect_val(ID_RS1, 32'h0000_0077, "x7_rewrite_stored");
    step();
    step();

    @(negedge clk);
    #1;
    n_total++;
    if (dbg_q.size() == 0) n_pass++;
    else $display("FAIL dbg_drain: got %0d pending expected 0", dbg_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/u_rf.md
Name: u_rf

Overview:
Integer register file and write-port responder for the RV32 pipeline.
- Serves the two operand read ports consumed by decode/execute.
- Sinks the delayed write-back stream (rf_rd_e/rf_rd_a/rf_rd_i) that the execute stage produces.
- Clears its storage with a post-reset sweep FSM instead of a bulk reset.
- Provides a req/ack debug read port for the testbench and debug logic.

Parameters:
XLEN, 32, data width of each register and of every data port
NREG, 32, number of architectural registers; address width is log2(NREG), 5 at default
BYPASS, 1, 1 = a write in cycle N is visible on the read ports in cycle N; 0 = visible from cycle N+1

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  reset; synchronous, active-high
rs1_a  in  5  read port 1 address
rs2_a  in  5  read port 2 address
rf_rs1_o  out  XLEN  read port 1 data, combinational
rf_rs2_o  out  XLEN  read port 2 data, combinational
rf_rd_e  in  1  write enable
rf_rd_a  in  5  write address
rf_rd_i  in  XLEN  write data
dbg_req  in  1  debug read request, level; held high until dbg_ack is seen
dbg_a  in  5  debug read address, stable while dbg_req is high
dbg_ack  out  1  debug read done, one-cycle pulse
dbg_d  out  XLEN  debug read data, valid while dbg_ack=1, held afterwards
init_busy  out  1  high while the clear sweep runs

Behaviour:
- Storage: NREG x XLEN flop array with no reset term. Entry 0 is never written and always reads as 0.
- FSM states: INIT and RUN.
  - While rst=1: state<=INIT, sweep counter cnt<=1, dbg_ack<=0, dbg_d<=0. init_busy=1.
  - INIT, each edge with rst=0: reg[cnt]<=0 and cnt<=cnt+1. When cnt==NREG-1, that final register is cleared and state<=RUN.
  - Consequence: init_busy stays high for exactly NREG-1 cycles after rst falls (31 at default).
  - RUN is the terminal state; only rst leaves it.
- init_busy = (state==INIT), a registered state decode.
- Writes:
  - In RUN, a write occurs at the edge when rf_rd_e=1 and rf_rd_a!=0: reg[rf_rd_a]<=rf_rd_i.
  - In INIT, writes are dropped silently with no retry.
  - Writes with rf_rd_a==0 are dropped.
- Reads (combinational, evaluated per port):
  - State INIT: output 0.
  - Address 0: output 0.
  - BYPASS=1 and rf_rd_e=1 and rf_rd_a==address (address nonzero): output rf_rd_i.
  - Otherwise: output reg[address].
  - Both ports may hit the same address and the bypass simultaneously.
- Debug port (RUN only):
  - If dbg_req=1 and dbg_ack=0 at an edge: dbg_d<=read value of dbg_a under the same read/bypass rules, and dbg_ack<=1.
  - On the next edge dbg_ack<=0, whatever dbg_req is.
  - The requester drops dbg_req in the cycle dbg_ack is high. A request still high then is treated as a new request, so maximum throughput is one read per 2 cycles.
  - In INIT, requests stall (dbg_ack stays 0) and are served in the first RUN cycle.
- Reset mid-operation:
  - Any pending dbg_req is abandoned and dbg_ack is forced to 0.
  - The sweep restarts from cnt=1.
  - All prior contents are lost.
- No X on outputs after the first rst edge: reads return 0 until the sweep completes.
- Address inputs >= NREG (only possible when NREG<32) read 0 and are ignored for writes.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> init_busy=1 for 31 cycles, then 0. Every address read via rs1_a/rs2_a returns 0x00000000.
- Write then read: in RUN, write x5=0xDEADBEEF at edge N -> rf_rs1_o with rs1_a=5 reads 0xDEADBEEF from cycle N+1. rs2_a=6 still reads 0.
- Bypass: rf_rd_e=1, rf_rd_a=9, rf_rd_i=0x12345678, rs1_a=rs2_a=9 in the same cycle -> both ports read 0x12345678 when BYPASS=1. With BYPASS=0 they read the old value 0 in that cycle and 0x12345678 in the next.
- x0 and INIT drops:
  - Write x0=0xFFFFFFFF -> x0 reads 0.
  - Write x3=0xAA during cycle 10 of the sweep -> x3 reads 0 after RUN is reached.
- Debug: x12=0xCAFEF00D, dbg_req=1 with dbg_a=12 -> dbg_ack=1 exactly one cycle later with dbg_d=0xCAFEF00D. Next cycle dbg_ack=0 and dbg_d holds 0xCAFEF00D.
- Reset mid-run: write x7=0x55, hold dbg_req=1 during init_busy, assert rst for 1 cycle -> dbg_ack=0 and the sweep restarts. After 31 cycles, dbg_ack pulses with dbg_d=0 for x7.
